// File: rtl/popcount_threshold_detector_pkg.sv
// Shared width helpers for the popcount-based voters.
// pt_clog2 : ceil(log2(v)), pt_clog2(1) == 0
// pt_cw    : width that holds any popcount of an n-bit word (0..n)
// pt_hw    : width that holds a run counter saturating at h (0..h)
package popcount_threshold_detector_pkg;

  function automatic int pt_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int pt_cw(input int n);
    return pt_clog2(n + 1);
  endfunction

  function automatic int pt_hw(input int h);
    return pt_clog2(h + 1);
  endfunction

endpackage

// File: rtl/popcount_threshold_detector_popcount.sv
// Combinational population count, built as a recursive adder tree:
// the word is split in half, each half is counted by a narrower
// instance, and the two partial counts are added.
// Ports:
//   in    [NBITS-1:0]  word to count
//   count [CW-1:0]     number of ones in `in`
module popcount_threshold_detector_popcount
  import popcount_threshold_detector_pkg::*;
#(
  parameter  int NBITS = 3,
  localparam int CW    = pt_cw(NBITS)
) (
  input  logic [NBITS-1:0] in,
  output logic [CW-1:0]    count
);

  generate
    if (NBITS == 1) begin : g_leaf
      assign count = in;
    end else begin : g_node
      localparam int NLO  = NBITS / 2;
      localparam int NHI  = NBITS - NLO;
      localparam int CWLO = pt_cw(NLO);
      localparam int CWHI = pt_cw(NHI);

      logic [CWLO-1:0] w_lo;
      logic [CWHI-1:0] w_hi;

      popcount_threshold_detector_popcount #(.NBITS(NLO)) u_lo (
        .in    (in[NLO-1:0]),
        .count (w_lo)
      );
      popcount_threshold_detector_popcount #(.NBITS(NHI)) u_hi (
        .in    (in[NBITS-1:NLO]),
        .count (w_hi)
      );

      // Sum of the halves never exceeds NBITS, so CW bits cannot overflow.
      assign count = CW'(w_lo) + CW'(w_hi);
    end
  endgenerate

endmodule

// File: rtl/popcount_threshold_detector.sv
// Registered "at least T of N" voter with a persistence filter.
// Ports:
//   clk, rst_n      rising-edge clock, async active-low reset
//   in_val, in      input word and its valid
//   thresh [CW]     minimum popcount for a match, sampled with `in`
//   out_val         registered copy of in_val
//   count  [CW]     popcount of the last valid word
//   match           count >= thresh for the last valid word
//   run    [HW]     consecutive valid matches, saturating at HOLD
//   persist         run == HOLD
module popcount_threshold_detector
  import popcount_threshold_detector_pkg::*;
#(
  parameter  int NBITS = 3,
  parameter  int HOLD  = 4,
  localparam int CW    = pt_cw(NBITS),
  localparam int HW    = pt_hw(HOLD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  input  logic [NBITS-1:0] in,
  input  logic [CW-1:0]    thresh,
  output logic             out_val,
  output logic [CW-1:0]    count,
  output logic             match,
  output logic [HW-1:0]    run,
  output logic             persist
);

  localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

  logic [CW-1:0] w_cnt;
  logic          w_match;
  logic [HW-1:0] w_run_nxt;

  logic          r_val;
  logic [CW-1:0] r_count;
  logic          r_match;
  logic [HW-1:0] r_run;

  popcount_threshold_detector_popcount #(.NBITS(NBITS)) u_pop (
    .in    (in),
    .count (w_cnt)
  );

  assign w_match = (w_cnt >= thresh);

  always_comb begin
    w_run_nxt = '0;
    if (w_match) w_run_nxt = (r_run == HOLD_V) ? r_run : r_run + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= 1'b0;
      r_count <= '0;
      r_match <= 1'b0;
      r_run   <= '0;
    end else begin
      r_val <= in_val;
      // Invalid cycles neither break nor extend a run.
      if (in_val) begin
        r_count <= w_cnt;
        r_match <= w_match;
        r_run   <= w_run_nxt;
      end
    end
  end

  assign out_val = r_val;
  assign count   = r_count;
  assign match   = r_match;
  assign run     = r_run;
  // Decoded from the run register, which was loaded from the next-state run,
  // so this rises on the same cycle the HOLD-th hit appears on match.
  assign persist = (r_run == HOLD_V);

endmodule

// File: tb/tb_popcount_threshold_detector.sv
module tb_popcount_threshold_detector;

  logic clk, rst_n;
  int total, bad;

  // u3: NBITS=3 HOLD=1 (CW=2, HW=1)
  logic a_iv, a_ov, a_m, a_p; logic [2:0] a_in; logic [1:0] a_th, a_c; logic [0:0] a_r;
  // u8: NBITS=8 HOLD=4 (CW=4, HW=3)
  logic b_iv, b_ov, b_m, b_p; logic [7:0] b_in; logic [3:0] b_th, b_c; logic [2:0] b_r;
  // u8h3: NBITS=8 HOLD=3 (CW=4, HW=2)
  logic c_iv, c_ov, c_m, c_p; logic [7:0] c_in; logic [3:0] c_th, c_c; logic [1:0] c_r;
  // u4: NBITS=4 HOLD=4 (CW=3, HW=3)
  logic d_iv, d_ov, d_m, d_p; logic [3:0] d_in; logic [2:0] d_th, d_c; logic [2:0] d_r;

  popcount_threshold_detector #(.NBITS(3), .HOLD(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_val(a_iv), .in(a_in), .thresh(a_th),
    .out_val(a_ov), .count(a_c), .match(a_m), .run(a_r), .persist(a_p));
  popcount_threshold_detector #(.NBITS(8), .HOLD(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_val(b_iv), .in(b_in), .thresh(b_th),
    .out_val(b_ov), .count(b_c), .match(b_m), .run(b_r), .persist(b_p));
  popcount_threshold_detector #(.NBITS(8), .HOLD(3)) u8h3 (
    .clk(clk), .rst_n(rst_n), .in_val(c_iv), .in(c_in), .thresh(c_th),
    .out_val(c_ov), .count(c_c), .match(c_m), .run(c_r), .persist(c_p));
  popcount_threshold_detector #(.NBITS(4), .HOLD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_val(d_iv), .in(d_in), .thresh(d_th),
    .out_val(d_ov), .count(d_c), .match(d_m), .run(d_r), .persist(d_p));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_iv = 0; a_in = 0; a_th = 0;
    b_iv = 0; b_in = 0; b_th = 0;
    c_iv = 0; c_in = 0; c_th = 0;
    d_iv = 0; d_in = 0; d_th = 0;
    #2;
    total++;
    if ({b_ov, b_c, b_m, b_r, b_p} !== 10'b0) begin
      bad++; $display("FAIL reset_u8 got=%b want=0", {b_ov, b_c, b_m, b_r, b_p});
    end
    total++;
    if ({a_ov, a_c, a_m, a_r, a_p} !== 6'b0) begin
      bad++; $display("FAIL reset_u3 got=%b want=0", {a_ov, a_c, a_m, a_r, a_p});
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_pair_triple();
    logic [1:0] exp_c [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [7:0] exp_m = 8'b1110_1000; // bit v set for v = 3,5,6,7
    a_th = 2'd2;
    for (int v = 0; v < 8; v++) begin
      a_iv = 1; a_in = 3'(v);
      step();
      total++;
      if (a_c !== exp_c[v] || a_m !== exp_m[v] || a_p !== exp_m[v] || a_ov !== 1'b1) begin
        bad++;
        $display("FAIL pair_triple in=%0d got c=%0d m=%b p=%b ov=%b want c=%0d m=%b p=%b ov=1",
                 v, a_c, a_m, a_p, a_ov, exp_c[v], exp_m[v], exp_m[v]);
      end
    end
    a_iv = 0;
  endtask

  task automatic test_persist();
    logic [2:0] exp_r [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [4:0] exp_p = 5'b11000; // index 3,4
    b_th = 4'd5;
    for (int i = 0; i < 5; i++) begin
      b_iv = 1; b_in = 8'hFF;
      step();
      total++;
      if (b_r !== exp_r[i] || b_p !== exp_p[i] || b_c !== 4'd8 || b_m !== 1'b1) begin
        bad++;
        $display("FAIL persist_hit%0d got r=%0d p=%b c=%0d m=%b want r=%0d p=%b c=8 m=1",
                 i, b_r, b_p, b_c, b_m, exp_r[i], exp_p[i]);
      end
    end
    b_in = 8'h01;
    step();
    total++;
    if (b_r !== 3'd0 || b_p !== 1'b0 || b_m !== 1'b0 || b_c !== 4'd1) begin
      bad++;
      $display("FAIL persist_break got r=%0d p=%b m=%b c=%0d want r=0 p=0 m=0 c=1", b_r, b_p, b_m, b_c);
    end
    b_iv = 0;
  endtask

  task automatic test_gaps();
    c_th = 4'd5;
    c_iv = 1; c_in = 8'hF8; // 5 ones
    step();
    total++;
    if (c_r !== 2'd1 || c_p !== 1'b0 || c_c !== 4'd5 || c_m !== 1'b1) begin
      bad++; $display("FAIL gap_hit1 got r=%0d p=%b c=%0d m=%b want r=1 p=0 c=5 m=1", c_r, c_p, c_c, c_m);
    end
    c_iv = 0; c_in = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (c_ov !== 1'b0 || c_c !== 4'd5 || c_m !== 1'b1 || c_r !== 2'd1) begin
        bad++;
        $display("FAIL gap_hold%0d got ov=%b c=%0d m=%b r=%0d want ov=0 c=5 m=1 r=1", i, c_ov, c_c, c_m, c_r);
      end
    end
    c_iv = 1; c_in = 8'hFF;
    step();
    total++;
    if (c_r !== 2'd2 || c_p !== 1'b0 || c_ov !== 1'b1) begin
      bad++; $display("FAIL gap_hit2 got r=%0d p=%b ov=%b want r=2 p=0 ov=1", c_r, c_p, c_ov);
    end
    step();
    total++;
    if (c_r !== 2'd3 || c_p !== 1'b1 || c_c !== 4'd8) begin
      bad++; $display("FAIL gap_hit3 got r=%0d p=%b c=%0d want r=3 p=1 c=8", c_r, c_p, c_c);
    end
    c_iv = 0;
  endtask

  task automatic test_thresh_extremes();
    b_iv = 1; b_in = 8'h00; b_th = 4'd0;
    step();
    total++;
    if (b_m !== 1'b1 || b_c !== 4'd0 || b_r !== 3'd1) begin
      bad++; $display("FAIL thresh0 got m=%b c=%0d r=%0d want m=1 c=0 r=1", b_m, b_c, b_r);
    end
    b_in = 8'hFF; b_th = 4'd9;
    step();
    total++;
    if (b_m !== 1'b0 || b_c !== 4'd8 || b_r !== 3'd0 || b_p !== 1'b0) begin
      bad++; $display("FAIL thresh9 got m=%b c=%0d r=%0d p=%b want m=0 c=8 r=0 p=0", b_m, b_c, b_r, b_p);
    end
    b_iv = 0;
    step();
  endtask

  task automatic test_async_reset();
    b_th = 4'd5; b_in = 8'hFF; b_iv = 1;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (b_r !== 3'd3) begin
      bad++; $display("FAIL arst_pre got r=%0d want r=3", b_r);
    end
    b_iv = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({b_ov, b_c, b_m, b_r, b_p} !== 10'b0) begin
      bad++; $display("FAIL arst_clear got=%b want=0", {b_ov, b_c, b_m, b_r, b_p});
    end
    #1 rst_n = 1;
    b_iv = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (b_r !== 3'(i + 1) || b_p !== (i == 3)) begin
        bad++; $display("FAIL arst_rehit%0d got r=%0d p=%b want r=%0d p=%b", i, b_r, b_p, i + 1, i == 3);
      end
    end
    b_iv = 0;
  endtask

  task automatic test_thresh_change();
    d_iv = 1; d_in = 4'b0111; d_th = 3'd3;
    step();
    total++;
    if (d_m !== 1'b1 || d_c !== 3'd3 || d_r !== 3'd1) begin
      bad++; $display("FAIL thr_chg_a got m=%b c=%0d r=%0d want m=1 c=3 r=1", d_m, d_c, d_r);
    end
    d_th = 3'd4;
    step();
    total++;
    if (d_m !== 1'b0 || d_c !== 3'd3 || d_r !== 3'd0) begin
      bad++; $display("FAIL thr_chg_b got m=%b c=%0d r=%0d want m=0 c=3 r=0", d_m, d_c, d_r);
    end
    d_iv = 0; d_in = 4'b1111;
    step();
    total++;
    if (d_ov !== 1'b0 || d_c !== 3'd3 || d_m !== 1'b0) begin
      bad++; $display("FAIL thr_chg_hold got ov=%b c=%0d m=%b want ov=0 c=3 m=0", d_ov, d_c, d_m);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_pair_triple();
    test_persist();
    test_gaps();
    test_thresh_extremes();
    test_async_reset();
    test_thresh_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/popcount_threshold_detector.md
Name: popcount_threshold_detector

Overview:
- Parametrised successor to the 3-input pair/triple (2-of-3 majority) detector.
- Counts asserted bits across an NBITS-wide input word and compares the count against a runtime threshold.
- Registers the result and adds a persistence filter: `persist` asserts only after HOLD consecutive valid matches.
- Used as a registered, debounced "at least T of N" voter in the datapath; NBITS=3 with thresh=2 reproduces the original combinational detector, one cycle late.

Parameters:
- NBITS, 3, width of the input word; legal range 1..32.
- HOLD, 4, consecutive valid matches required before `persist` asserts; legal range 1..255.
- CW, $clog2(NBITS+1), width of count and threshold (localparam, not overridable).
- HW, $clog2(HOLD+1), width of the run counter (localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_val  input  1  `in` is valid this cycle.
- in  input  NBITS  data word to vote on.
- thresh  input  CW  minimum popcount for a match; sampled with `in` when in_val=1.
- out_val  output  1  `count`/`match` valid; registered copy of in_val.
- count  output  CW  registered popcount of the last sampled word.
- match  output  1  registered (popcount >= thresh) for the last sampled word.
- run  output  HW  consecutive-match run length; saturates at HOLD.
- persist  output  1  run == HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): out_val=0, count=0, match=0, run=0, persist=0. Deassertion is sampled at the next clk edge.
- Latency: one cycle. An edge with in_val=1 loads count=popcount(in) and match=(popcount(in) >= thresh), with an unsigned compare at CW bits; out_val=1 after that edge.
- Edge with in_val=0: out_val=0; count and match hold their previous values.
- Run counter, updated only on edges where in_val=1:
  - new match=1 and run<HOLD: run+1.
  - new match=1 and run==HOLD: hold (saturate, no wrap).
  - new match=0: run=0.
- Edges with in_val=0 hold run: invalid gaps neither break nor extend a run.
- persist is registered, derived from the next-state run, so it asserts in the same cycle match first completes the HOLD-th consecutive hit. HOLD=1 gives persist==match on valid cycles.
- Boundaries:
  - thresh=0: every valid word matches, including in=0.
  - thresh>NBITS: never matches; run stays 0.
  - in all ones: count=NBITS, with no overflow because CW covers NBITS.
  - thresh changes mid-run: only the value sampled with each valid word applies; no retroactive effect.
  - rst_n asserted mid-run: all state clears at once; the first valid word after reset starts at run=0.
- No internal state other than the count, match, out_val and run registers. Purely synchronous apart from the reset.

Decomposition:
- Shared header/package: CW and HW width-function macros and a common $clog2 helper, reused by future voters.
- One natural sub-module: popcount (combinational, parameter NBITS, output CW bits), implemented as an adder tree. The top level instantiates it and holds only the registers and the run/persist logic.

Test Plan:
1. Pair/triple equivalence: NBITS=3, HOLD=1, thresh=2; apply all 8 values of `in` with in_val=1. Next cycle: match=1 exactly for 3,5,6,7; count equals popcount; persist==match.
2. Persistence: NBITS=8, HOLD=4, thresh=5; in=8'hFF for 4 valid cycles. run goes 1,2,3,4; persist=1 on the 4th output cycle. A 5th hit keeps run=4 (saturated). Then in=8'h01 gives run=0, persist=0.
3. Invalid gaps: HOLD=3; hit, in_val=0 for 2 cycles, hit, hit. persist asserts on the 3rd valid hit; out_val=0 and count/match hold during the gap.
4. Threshold extremes: NBITS=8. thresh=0 with in=0 gives match=1, count=0. thresh=9 with in=8'hFF gives match=0, count=8, run=0.
5. Async reset mid-run: HOLD=4, run=3; pulse rst_n low between edges. All outputs are 0 before the next edge. After release, 4 hits are needed for persist.
6. Runtime threshold change: NBITS=4; in=4'b0111 with thresh=3, then thresh=4 on the next word. Responses are match=1 then match=0, and run resets to 0.
